// File: rtl/rd_ram_source_ctrl_pp_if.sv
// Bus bundle for the RAM-to-FIFO source controller.
// The slave modport is the controller's view. The master modport is the
// environment's view: requester, RAM and downstream FIFO.
interface rd_ram_source_ctrl_pp_if #(
  parameter int DATA_W = 16,
  parameter int OFS_W  = 9,
  parameter int BUF_W  = 1,
  parameter int LEN_W  = 16
);
  // request side
  logic                   start;
  logic [BUF_W-1:0]       start_buf;
  logic [LEN_W-1:0]       dat_length;
  logic                   abort;
  // RAM side
  logic                   ram_ready;
  logic                   ram_rd_en;
  logic [BUF_W+OFS_W-1:0] ram_addr;
  logic [DATA_W-1:0]      ram_dout;
  // FIFO side
  logic                   out_afull;
  logic [DATA_W-1:0]      dat_out;
  logic                   en_out;
  // status
  logic                   busy;
  logic                   done;
  logic [BUF_W-1:0]       done_buf;
  logic                   err_len;

  modport slave (
    input  start, start_buf, dat_length, abort, ram_ready, out_afull, ram_dout,
    output ram_rd_en, ram_addr, dat_out, en_out, busy, done, done_buf, err_len
  );

  modport master (
    output start, start_buf, dat_length, abort, ram_ready, out_afull, ram_dout,
    input  ram_rd_en, ram_addr, dat_out, en_out, busy, done, done_buf, err_len
  );
endinterface

// File: rtl/rd_ram_source_ctrl_pp.sv
// Streams a byte-length-defined record out of one of 2^BUF_W equal RAM
// buffers into a downstream FIFO. It honours registered almost-full
// backpressure and supports a RAM read latency of 1..3 cycles.
module rd_ram_source_ctrl_pp #(
  parameter int DATA_W = 16,
  parameter int OFS_W  = 9,
  parameter int BUF_W  = 1,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  rd_ram_source_ctrl_pp_if.slave bus
);

  localparam int BPW = DATA_W / 8;
  localparam logic [LEN_W:0] DEPTH   = (LEN_W+1)'(1) << OFS_W;
  localparam logic [OFS_W:0] DEPTH_W = (OFS_W+1)'(1) << OFS_W;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, READ, DRAIN, DONE} state_t;

  state_t                 state;
  logic [BUF_W-1:0]       buf_q;
  logic [OFS_W:0]         words_q;
  logic [OFS_W:0]         cnt;       // words already issued, including the one on the bus now
  logic                   afull_q;
  logic                   rd_en;
  logic [BUF_W+OFS_W-1:0] addr;
  logic [RD_LAT:1]        vld;       // vld[k] marks a word issued k cycles ago
  logic [DATA_W-1:0]      dat_q;
  logic                   en_q;
  logic                   busy_q;
  logic                   done_q;
  logic [BUF_W-1:0]       done_buf_q;
  logic                   err_q;

  logic [LEN_W:0]         len_round;
  logic [LEN_W:0]         words_raw;
  logic                   over;
  logic [OFS_W:0]         words_req;
  logic                   abort_take;

  // Word count for the incoming request: round bytes up to whole words, then clamp to one buffer.
  // NOTE: each signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    len_round = {1'b0, bus.dat_length} + (LEN_W+1)'(BPW - 1);
    words_raw = len_round / (LEN_W+1)'(BPW);
    over      = words_raw > DEPTH;
    words_req = over ? DEPTH_W : words_raw[OFS_W:0];
  end

  assign abort_take = bus.abort && (state != IDLE);

  // Control FSM with registered RAM strobe, address and status outputs.
  // NOTE: state uses non-blocking assignments, so every branch reads the pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous and is sampled only on the clock edge.
    if (reset) begin
      state      <= IDLE;
      buf_q      <= '0;
      words_q    <= '0;
      cnt        <= '0;
      afull_q    <= 1'b0;
      rd_en      <= 1'b0;
      addr       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_buf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      afull_q <= bus.out_afull;
      done_q  <= 1'b0;
      if (abort_take) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        rd_en  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              buf_q   <= bus.start_buf;
              words_q <= words_req;
              err_q   <= over;
              busy_q  <= 1'b1;
              cnt     <= '0;
              if (words_req == '0) begin
                state      <= DONE;
                done_q     <= 1'b1;
                done_buf_q <= bus.start_buf;
              end else begin
                state <= WAIT_RDY;
              end
            end
          end
          WAIT_RDY: begin
            if (bus.ram_ready && !afull_q) begin
              // NOTE: the next-cycle value of afull_q is out_afull now. The strobe is
              // therefore decided one edge early from out_afull, which gives the same
              // cycle behaviour as gating a combinational strobe with afull_q.
              state <= READ;
              addr  <= {buf_q, {OFS_W{1'b0}}};
              rd_en <= !bus.out_afull;
              cnt   <= {{OFS_W{1'b0}}, !bus.out_afull};
            end
          end
          READ: begin
            if (cnt == words_q) begin
              // the last word is on the bus in this cycle
              rd_en <= 1'b0;
              state <= DRAIN;
            end else begin
              rd_en <= !bus.out_afull;
              if (!bus.out_afull) begin
                addr <= {buf_q, cnt[OFS_W-1:0]};
                cnt  <= cnt + (OFS_W+1)'(1);
              end
            end
          end
          DRAIN: begin
            if (vld == '0) begin
              state      <= DONE;
              done_q     <= 1'b1;
              done_buf_q <= buf_q;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read-data pipeline: track issued words for RD_LAT cycles, then forward RAM data to the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= '0;
      en_q  <= 1'b0;
      dat_q <= '0;
    end else if (abort_take) begin
      vld  <= '0;
      en_q <= 1'b0;
    end else begin
      vld[1] <= rd_en;
      for (int i = 2; i <= RD_LAT; i++) vld[i] <= vld[i-1];
      en_q <= vld[RD_LAT];
      if (vld[RD_LAT]) dat_q <= bus.ram_dout;
    end
  end

  assign bus.ram_rd_en = rd_en;
  assign bus.ram_addr  = addr;
  assign bus.dat_out   = dat_q;
  assign bus.en_out    = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_buf  = done_buf_q;
  assign bus.err_len   = err_q;

endmodule
